// File: rtl/rom_4x4_async_pkg.sv
// rom_4x4_async_pkg
// Shared definitions for the 4x4 constant lookup table:
//   - default word width, address width and packed contents
//   - rom_word(): pulls word idx out of a packed init vector
// Every consumer pulls these in with import rom_4x4_async_pkg::*.
package rom_4x4_async_pkg;

  localparam int unsigned DATA_W_DEF = 4;
  localparam int unsigned ADDR_W_DEF = 2;

  // Word i lives in bits [i*DATA_W +: DATA_W]: 0->A, 1->5, 2->F, 3->0.
  localparam logic [15:0] ROM_INIT_DEF = 16'h0F5A;

  // Upper bounds for the helper's working vectors. They are wide enough
  // for any reasonable instance of this table.
  localparam int unsigned INIT_MAX_W = 1024;
  localparam int unsigned WORD_MAX_W = 32;

  // Returns word idx of a packed init vector whose words are w bits wide.
  // Bits above w in the result are zero. The caller keeps the low bits.
  function automatic logic [WORD_MAX_W-1:0] rom_word(
    input logic [INIT_MAX_W-1:0] init,
    input int unsigned           idx,
    input int unsigned           w
  );
    logic [WORD_MAX_W-1:0] word;
    logic [9:0]            pos;
    word = '0;
    for (int b = 0; b < WORD_MAX_W; b++) begin
      if (b < int'(w)) begin
        pos     = 10'(idx * w + b);
        word[b] = init[pos];
      end
    end
    return word;
  endfunction

endpackage

// File: rtl/rom_4x4_core.sv
// rom_4x4_core
// Purely combinational word lookup. Contents are fixed at elaboration.
// The read path contains no clock or reset.
// Ports:
//   address  in  ADDR_W  read index (every value is in range)
//   rom_data out DATA_W  word stored at address
module rom_4x4_core
  import rom_4x4_async_pkg::*;
#(
  parameter int unsigned                          DATA_W   = DATA_W_DEF,
  parameter int unsigned                          ADDR_W   = ADDR_W_DEF,
  parameter logic [DATA_W*(2**ADDR_W)-1:0]        ROM_INIT = ROM_INIT_DEF
) (
  input  logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] rom_data
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] words [DEPTH];

  // Unpack the init vector into a constant table once, at elaboration.
  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    localparam logic [WORD_MAX_W-1:0] WORD =
      rom_word(INIT_MAX_W'(ROM_INIT), i, DATA_W);
    assign words[i] = WORD[DATA_W-1:0];
  end

  // Depth equals 2**ADDR_W, so no out-of-range guard is needed.
  assign rom_data = words[address];

endmodule

// File: rtl/rom_4x4_async.sv
// rom_4x4_async
// Four-word constant table with a combinational read, plus a registered
// copy of the read data, its parity, a valid flag and an address-change
// pulse for synchronous consumers.
// Ports:
//   clk          in  1       rising-edge clock
//   rst_n        in  1       asynchronous active-low reset
//   address      in  ADDR_W  read index
//   rom_data_out out DATA_W  combinational read data (live during reset)
//   rom_data_q   out DATA_W  rom_data_out registered on clk
//   rom_parity_q out 1       XOR reduction of rom_data_q
//   data_valid   out 1       rom_data_q holds a word sampled after reset
//   addr_changed out 1       one-cycle pulse when the sampled address moves
module rom_4x4_async
  import rom_4x4_async_pkg::*;
#(
  parameter int unsigned                   DATA_W   = DATA_W_DEF,
  parameter int unsigned                   ADDR_W   = ADDR_W_DEF,
  parameter logic [DATA_W*(2**ADDR_W)-1:0] ROM_INIT = ROM_INIT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] rom_data_out,
  output logic [DATA_W-1:0] rom_data_q,
  output logic              rom_parity_q,
  output logic              data_valid,
  output logic              addr_changed
);

  function automatic logic even_parity(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

  logic [ADDR_W-1:0] addr_p1;

  // Stage p0: combinational lookup
  rom_4x4_core #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .ROM_INIT (ROM_INIT)
  ) u_core (
    .address  (address),
    .rom_data (rom_data_out)
  );

  // Stage p1: registered mirror, parity, valid and change detect.
  // The change detect is gated by data_valid, so the first edge after
  // reset compares against nothing and stays quiet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_data_q   <= '0;
      rom_parity_q <= 1'b0;
      addr_p1      <= '0;
      data_valid   <= 1'b0;
      addr_changed <= 1'b0;
    end else begin
      rom_data_q   <= rom_data_out;
      rom_parity_q <= even_parity(rom_data_out);
      addr_p1      <= address;
      data_valid   <= 1'b1;
      addr_changed <= data_valid & (address != addr_p1);
    end
  end

endmodule

// File: tb/tb_rom_4x4_async.sv
module tb_rom_4x4_async;

  logic       clk;
  logic       clk_en;
  logic       rst_n;
  logic [1:0] address;

  logic [3:0] a_out, a_q;
  logic       a_par, a_vld, a_chg;
  logic [3:0] b_out, b_q;
  logic       b_par, b_vld, b_chg;

  int passed;
  int total;

  rom_4x4_async dut_a (
    .clk          (clk),
    .rst_n        (rst_n),
    .address      (address),
    .rom_data_out (a_out),
    .rom_data_q   (a_q),
    .rom_parity_q (a_par),
    .data_valid   (a_vld),
    .addr_changed (a_chg)
  );

  rom_4x4_async #(.ROM_INIT(16'h1234)) dut_b (
    .clk          (clk),
    .rst_n        (rst_n),
    .address      (address),
    .rom_data_out (b_out),
    .rom_data_q   (b_q),
    .rom_parity_q (b_par),
    .data_valid   (b_vld),
    .addr_changed (b_chg)
  );

  always #5 clk = clk_en ? ~clk : 1'b0;

  task automatic check4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hand-computed tables
  logic [3:0] exp_a [4];
  logic [3:0] exp_b [4];
  logic       par_b [4];

  initial begin
    exp_a[0] = 4'hA; exp_a[1] = 4'h5; exp_a[2] = 4'hF; exp_a[3] = 4'h0;
    exp_b[0] = 4'h4; exp_b[1] = 4'h3; exp_b[2] = 4'h2; exp_b[3] = 4'h1;
    par_b[0] = 1'b1; par_b[1] = 1'b0; par_b[2] = 1'b1; par_b[3] = 1'b1;
    passed  = 0;
    total   = 0;
    clk     = 1'b0;
    clk_en  = 1'b0;
    rst_n   = 1'b0;
    address = 2'd0;

    // Reset held, no clock: async read works, registers stay cleared
    for (int i = 0; i < 4; i++) begin
      address = 2'(i);
      #5;
      check4($sformatf("rst_out_a%0d", i), a_out, exp_a[i]);
      check4($sformatf("rst_out_b%0d", i), b_out, exp_b[i]);
      check4($sformatf("rst_q%0d", i), a_q, 4'h0);
      check1($sformatf("rst_vld%0d", i), a_vld, 1'b0);
      check1($sformatf("rst_chg%0d", i), a_chg, 1'b0);
    end
    check1("rst_par", a_par, 1'b0);

    // Release reset mid-cycle with address=2, then one edge
    clk_en  = 1'b1;
    address = 2'd2;
    #3;
    rst_n = 1'b1;
    #1;
    check1("rel_vld_before_edge", a_vld, 1'b0);
    tick();
    check4("first_q", a_q, 4'hF);
    check1("first_par", a_par, 1'b0);
    check1("first_vld", a_vld, 1'b1);
    check1("first_chg", a_chg, 1'b0);
    check4("first_q_b", b_q, 4'h2);
    check1("first_par_b", b_par, 1'b1);

    // Sweep 0..3, one per cycle; every sample differs from the previous
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      address = 2'(i);
      #1;
      check4($sformatf("sweep_out%0d", i), a_out, exp_a[i]);
      check4($sformatf("sweep_lag%0d", i), a_q, (i == 0) ? 4'hF : exp_a[i-1]);
      tick();
      check4($sformatf("sweep_q%0d", i), a_q, exp_a[i]);
      check1($sformatf("sweep_par%0d", i), a_par, 1'b0);
      check1($sformatf("sweep_chg%0d", i), a_chg, 1'b1);
      check4($sformatf("sweep_q_b%0d", i), b_q, exp_b[i]);
      check1($sformatf("sweep_par_b%0d", i), b_par, par_b[i]);
      check1($sformatf("sweep_chg_b%0d", i), b_chg, 1'b1);
    end

    // Hold address 1 for three cycles
    @(negedge clk);
    address = 2'd1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check4($sformatf("hold_q%0d", i), a_q, 4'h5);
      check1($sformatf("hold_chg%0d", i), a_chg, (i == 0) ? 1'b1 : 1'b0);
      check1($sformatf("hold_vld%0d", i), a_vld, 1'b1);
    end

    // Load F, then assert reset between edges
    @(negedge clk);
    address = 2'd2;
    tick();
    check4("pre_rst_q", a_q, 4'hF);
    #2;
    rst_n = 1'b0;
    #1;
    check4("async_rst_q", a_q, 4'h0);
    check1("async_rst_vld", a_vld, 1'b0);
    check1("async_rst_par", a_par, 1'b0);
    check1("async_rst_chg", a_chg, 1'b0);
    check4("async_rst_q_b", b_q, 4'h0);
    address = 2'd0;
    #1;
    check4("rst_track_out", a_out, 4'hA);

    // Edge while still in reset: registers must stay cleared
    tick();
    check4("held_rst_q", a_q, 4'h0);
    check1("held_rst_vld", a_vld, 1'b0);

    // Release with an address differing from the cleared addr register:
    // first sample after reset must not pulse addr_changed
    @(negedge clk);
    address = 2'd3;
    rst_n   = 1'b1;
    tick();
    check4("rerel_q", a_q, 4'h0);
    check1("rerel_vld", a_vld, 1'b1);
    check1("rerel_chg", a_chg, 1'b0);
    check4("rerel_q_b", b_q, 4'h1);
    check1("rerel_par_b", b_par, 1'b1);

    // Next change after that does pulse, and only for one cycle
    @(negedge clk);
    address = 2'd0;
    tick();
    check1("post_chg", a_chg, 1'b1);
    check4("post_q", a_q, 4'hA);
    tick();
    check1("post_chg_drop", a_chg, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
